// File: rtl/sdram_burst_arbiter.sv
// ----------------------------------------------------------------------------
// sdram_burst_arbiter
//
// Shares the single SDRAM burst port between the cache line-fill path (read)
// and the write-buffer drain path (write). One burst command is issued per
// grant. The grant is held until BURST_LEN data beats for that direction have
// been counted. A single DONE cycle then follows, which guarantees a one-cycle
// bubble between bursts.
//
// Arbitration in IDLE, highest priority first:
//   1. wr_req & wr_urgent                  (buffer full / tag conflict)
//   2. wr_req & read streak exhausted      (bounds write starvation)
//   3. rd_req
//   4. wr_req
//
// Ports:
//   clk_i, rst_ni          clock; asynchronous active-low reset
//   rd_req_i, rd_addr_i    line-fill request (level) and line address
//   wr_req_i, wr_addr_i    drain request (level) and line address
//   wr_urgent_i            raises write priority
//   mem_cmd_valid_o/ready_i/wr_o/addr_o   burst command handshake to SDRAM ctrl
//   mem_rxd_i, mem_txd_i   read beat delivered / write beat consumed
//   rd_gnt_o, wr_gnt_o     current owner of the port
//   rd_done_o, wr_done_o   one-cycle burst-complete pulses
//   beat_cnt_o             beat index within the current burst
// ----------------------------------------------------------------------------
module sdram_burst_arbiter #(
   parameter int ADDR_W        = 22,
   parameter int BURST_LEN     = 8,
   parameter int MAX_RD_STREAK = 4
) (
   input  logic                         clk_i,
   input  logic                         rst_ni,

   input  logic                         rd_req_i,
   input  logic [ADDR_W-1:0]            rd_addr_i,
   input  logic                         wr_req_i,
   input  logic [ADDR_W-1:0]            wr_addr_i,
   input  logic                         wr_urgent_i,

   output logic                         mem_cmd_valid_o,
   input  logic                         mem_cmd_ready_i,
   output logic                         mem_cmd_wr_o,
   output logic [ADDR_W-1:0]            mem_cmd_addr_o,
   input  logic                         mem_rxd_i,
   input  logic                         mem_txd_i,

   output logic                         rd_gnt_o,
   output logic                         wr_gnt_o,
   output logic                         rd_done_o,
   output logic                         wr_done_o,
   output logic [$clog2(BURST_LEN)-1:0] beat_cnt_o
);

   localparam int BEAT_W   = $clog2(BURST_LEN);
   localparam int STREAK_W = $clog2(MAX_RD_STREAK + 1);

   localparam logic [BEAT_W-1:0]   BEAT_LAST  = BEAT_W'(BURST_LEN - 1);
   localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_RD_STREAK);

   if (BURST_LEN < 2 || (BURST_LEN & (BURST_LEN - 1)) != 0) begin : g_bad_burst_len
      $error("BURST_LEN must be a power of 2 and at least 2");
   end
   if (MAX_RD_STREAK < 1) begin : g_bad_streak
      $error("MAX_RD_STREAK must be at least 1");
   end

   // state  | meaning
   // IDLE   | port free; arbitrate pending requests
   // CMD    | burst command presented, waiting for mem_cmd_ready_i
   // XFER   | counting data beats of the granted direction
   // DONE   | done pulse for the finished burst; grant already dropped
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CMD  = 2'd1,
      S_XFER = 2'd2,
      S_DONE = 2'd3
   } state_e;

   state_e               state_q,  state_d;
   logic                 dir_wr_q, dir_wr_d;
   logic [ADDR_W-1:0]    addr_q,   addr_d;
   logic [BEAT_W-1:0]    beat_q,   beat_d;
   logic [STREAK_W-1:0]  streak_q, streak_d;

   logic                 streak_full;
   logic                 beat_hit;
   logic                 owns_port;

   assign streak_full = (streak_q == STREAK_MAX);

   // Only the strobe of the granted direction advances the beat count.
   assign beat_hit = dir_wr_q ? mem_txd_i : mem_rxd_i;

   always_comb begin
      state_d  = state_q;
      dir_wr_d = dir_wr_q;
      addr_d   = addr_q;
      beat_d   = beat_q;
      streak_d = streak_q;

      case (state_q)
         S_IDLE: begin
            // With no write waiting there is nothing to starve.
            if (!wr_req_i) begin
               streak_d = '0;
            end

            if (wr_req_i && (wr_urgent_i || streak_full)) begin
               state_d  = S_CMD;
               dir_wr_d = 1'b1;
               addr_d   = wr_addr_i;
               streak_d = '0;
            end else if (rd_req_i) begin
               state_d  = S_CMD;
               dir_wr_d = 1'b0;
               addr_d   = rd_addr_i;
               if (wr_req_i && !streak_full) begin
                  streak_d = streak_q + STREAK_W'(1);
               end
            end else if (wr_req_i) begin
               state_d  = S_CMD;
               dir_wr_d = 1'b1;
               addr_d   = wr_addr_i;
               streak_d = '0;
            end
         end

         S_CMD: begin
            if (mem_cmd_ready_i) begin
               state_d = S_XFER;
               beat_d  = '0;
            end
         end

         S_XFER: begin
            if (beat_hit) begin
               if (beat_q == BEAT_LAST) begin
                  beat_d  = '0;
                  state_d = S_DONE;
               end else begin
                  beat_d = beat_q + BEAT_W'(1);
               end
            end
         end

         S_DONE: begin
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q  <= S_IDLE;
         dir_wr_q <= 1'b0;
         addr_q   <= '0;
         beat_q   <= '0;
         streak_q <= '0;
      end else begin
         state_q  <= state_d;
         dir_wr_q <= dir_wr_d;
         addr_q   <= addr_d;
         beat_q   <= beat_d;
         streak_q <= streak_d;
      end
   end

   // All outputs decode directly from registered state, so an asynchronous
   // reset forces them low immediately, even mid-burst.
   assign owns_port = (state_q == S_CMD) || (state_q == S_XFER);

   assign mem_cmd_valid_o = (state_q == S_CMD);
   assign mem_cmd_wr_o    = dir_wr_q;
   assign mem_cmd_addr_o  = addr_q;

   assign rd_gnt_o  = owns_port && !dir_wr_q;
   assign wr_gnt_o  = owns_port &&  dir_wr_q;
   assign rd_done_o = (state_q == S_DONE) && !dir_wr_q;
   assign wr_done_o = (state_q == S_DONE) &&  dir_wr_q;

   assign beat_cnt_o = beat_q;

endmodule

// File: doc/sdram_burst_arbiter.md
Name: sdram_burst_arbiter

Overview:
Arbitrates the single SDRAM burst port between the cache line-fill path (read) and the write-buffer drain path (write). It issues one burst command per grant and holds the grant until the burst completes, counting data beats. A fixed-priority-with-aging policy is used: urgent writes from a full or conflicting buffer go first, reads go next, and a streak counter bounds write starvation. It sits between the cache/write-buffer controllers and the SDRAM controller.

Parameters:
ADDR_W, 22, SDRAM line address width
BURST_LEN, 8, data beats per burst; must be a power of 2 and at least 2
MAX_RD_STREAK, 4, consecutive read grants allowed while a write is pending; must be at least 1

Ports:
Clk  input  1  clock; all state updates on the rising edge
Reset  input  1  asynchronous, active-low reset
rd_req  input  1  line-fill request; level, held until rd_done
rd_addr  input  ADDR_W  fill line address; stable while rd_req is high
wr_req  input  1  write-buffer drain request; level, held until wr_done
wr_addr  input  ADDR_W  drain line address; stable while wr_req is high
wr_urgent  input  1  write buffer full or tag conflict; raises write priority
mem_cmd_valid  output  1  burst command valid
mem_cmd_ready  input  1  SDRAM controller accepts the command
mem_cmd_wr  output  1  1 = write burst, 0 = read burst
mem_cmd_addr  output  ADDR_W  burst line address
mem_rxd  input  1  one read beat delivered this cycle
mem_txd  input  1  one write beat consumed this cycle
rd_gnt  output  1  read path owns the port
wr_gnt  output  1  write path owns the port
rd_done  output  1  one-cycle pulse: read burst finished
wr_done  output  1  one-cycle pulse: write burst finished
beat_cnt  output  log2(BURST_LEN)  beat index of the current burst

Behaviour:
- Reset values: all outputs 0, state IDLE, streak counter 0. Reset is honoured in any state, including mid-burst; the burst is abandoned with no done pulse.
- State IDLE:
  - Arbitration priority, highest first: (wr_req & wr_urgent); (wr_req & streak==MAX_RD_STREAK); rd_req; wr_req.
  - On a win: latch the direction and address, assert the matching gnt, go to CMD. Gnt becomes visible in the cycle after the request.
- State CMD:
  - mem_cmd_valid=1; mem_cmd_wr and mem_cmd_addr come from the latched values.
  - Hold until mem_cmd_ready. Valid, wr and addr must stay stable while waiting.
  - On handshake: drop valid, set beat_cnt=0, go to XFER.
- State XFER:
  - Count mem_rxd beats when reading and mem_txd beats when writing; ignore the strobe for the other direction.
  - On the beat where beat_cnt==BURST_LEN-1: pulse the done for this direction in the next cycle, drop gnt in that same cycle, go to DONE.
  - beat_cnt wraps to 0 after the final beat.
- State DONE: one cycle, gnt low; return to IDLE. This gives a guaranteed one-cycle bubble between bursts.
- Streak counter:
  - Increments on each read grant issued while wr_req is high, saturating at MAX_RD_STREAK.
  - Clears on any write grant.
  - Clears in IDLE when wr_req is low.
- Requests that drop before their grant are ignored; no grant is issued.
- Requests that drop after their grant do not abort the burst.
- rd_gnt and wr_gnt are never high together.
- Beat strobes received in IDLE, CMD or DONE are ignored.
- A new wr_urgent arriving during a read burst does not pre-empt it; it takes effect at the next IDLE.
- Latency for an idle port with immediate ready: request at cycle 0, gnt and cmd_valid at cycle 1, XFER from cycle 2, done at 2+BURST_LEN+beat stalls.

Test Plan:
- Single read: rd_req=1, addr=0x00123, ready immediate, 8 consecutive mem_rxd → cmd_wr=0, addr 0x00123, rd_done pulses once at cycle 10, rd_gnt high cycles 1–9.
- Simultaneous request: rd_req=1 and wr_req=1 with wr_urgent=0 → read granted first. Then assert wr_urgent during that burst with rd_req re-raised → the write is granted next, ahead of the read.
- Starvation bound: wr_req held, rd_req re-asserted after every rd_done → exactly 4 read bursts, then a write burst, and the streak returns to 0.
- Command backpressure: mem_cmd_ready low for 5 cycles → cmd_valid and addr stable throughout; XFER entered the cycle after ready.
- Beat gaps and wrong-direction strobes: write burst with mem_txd toggling 1,0,1,… and spurious mem_rxd → wr_done only after the 8th txd; beat_cnt reaches 7 and then wraps to 0.
- Reset mid-XFER at beat 3 → all outputs 0 immediately (asynchronous); no done pulse; the next request restarts from CMD.
